// File: rtl/serial_gpio_bridge.sv
// Byte-command bridge from a UART rx/tx pair to NUM_PORTS GPIO ports of GP_WIDTH bits.
// Write frames carry the port index, then NB data bytes MSB first; reads return NB bytes.
module serial_gpio_bridge #(
  parameter int         NUM_PORTS      = 4,
  parameter int         GP_WIDTH       = 16,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'hA5,
  parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  output logic [NUM_PORTS*GP_WIDTH-1:0] gp_out,
  input  logic [NUM_PORTS*GP_WIDTH-1:0] gp_in,
  output logic [NUM_PORTS-1:0]          wr_strobe
);

  localparam int NB  = GP_WIDTH / 8;
  localparam int BCW = $clog2(NB + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WDATA, WCOMMIT, TXWAIT, TXSEND, TXHOLD} state_t;

  state_t                        state_q;
  logic [6:0]                    port_q;
  logic [BCW-1:0]                bcnt_q;
  logic [BCW-1:0]                scnt_q;
  logic [TW-1:0]                 tmo_q;
  logic [GP_WIDTH-1:0]           asm_q;
  logic [GP_WIDTH-1:0]           shift_q;
  logic [NUM_PORTS*GP_WIDTH-1:0] gp_out_q;
  logic [NUM_PORTS-1:0]          wr_strobe_q;
  logic                          tx_start_q;
  logic [7:0]                    tx_data_q;

  logic [GP_WIDTH-1:0] rd_sel;
  logic                idx_ok;

  function automatic logic [GP_WIDTH-1:0] top_byte(input logic [7:0] b);
    logic [GP_WIDTH-1:0] r;
    r = '0;
    r[GP_WIDTH-1 -: 8] = b;
    return r;
  endfunction

  function automatic logic [GP_WIDTH-1:0] shift_in(input logic [GP_WIDTH-1:0] cur,
                                                   input logic [7:0] b);
    logic [GP_WIDTH-1:0] r;
    r = cur << 8;
    r[7:0] = b;
    return r;
  endfunction

  // Mux rather than a variable part-select so an out-of-range index never reads past gp_in.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rx_data[6:0] == 7'(k)) rd_sel = gp_in[k*GP_WIDTH +: GP_WIDTH];
    end
  end

  assign idx_ok = ({1'b0, rx_data[6:0]} < 8'(NUM_PORTS));

  always_ff @(posedge clk) begin
    wr_strobe_q <= '0;
    tx_start_q  <= 1'b0;
    if (!rst) begin
      state_q   <= IDLE;
      port_q    <= '0;
      bcnt_q    <= '0;
      scnt_q    <= '0;
      tmo_q     <= '0;
      gp_out_q  <= '0;
      tx_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if (!idx_ok) begin
              shift_q <= top_byte(ERR_BYTE);
              scnt_q  <= BCW'(1);
              state_q <= TXWAIT;
            end else if (rx_data[7]) begin
              port_q  <= rx_data[6:0];
              bcnt_q  <= '0;
              tmo_q   <= '0;
              state_q <= WDATA;
            end else begin
              shift_q <= rd_sel;
              scnt_q  <= BCW'(NB);
              state_q <= TXWAIT;
            end
          end
        end
        WDATA: begin
          // A byte arriving on the terminal-count cycle still counts.
          if (rx_valid) begin
            asm_q  <= shift_in(asm_q, rx_data);
            tmo_q  <= '0;
            bcnt_q <= bcnt_q + BCW'(1);
            if (bcnt_q == BCW'(NB - 1)) state_q <= WCOMMIT;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
            shift_q <= top_byte(ERR_BYTE);
            scnt_q  <= BCW'(1);
            state_q <= TXWAIT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        WCOMMIT: begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_q == 7'(k)) begin
              gp_out_q[k*GP_WIDTH +: GP_WIDTH] <= asm_q;
              wr_strobe_q[k]                   <= 1'b1;
            end
          end
          shift_q <= top_byte(ACK_BYTE);
          scnt_q  <= BCW'(1);
          state_q <= TXWAIT;
        end
        TXWAIT: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= shift_q[GP_WIDTH-1 -: 8];
            state_q    <= TXSEND;
          end
        end
        TXSEND: begin
          shift_q <= shift_q << 8;
          scnt_q  <= scnt_q - BCW'(1);
          state_q <= TXHOLD;
        end
        TXHOLD: begin
          // tx_busy is not trusted yet here; the transmitter may not have raised it.
          state_q <= (scnt_q != '0) ? TXWAIT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign gp_out    = gp_out_q;
  assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_serial_gpio_bridge.sv
// Directed bench for serial_gpio_bridge with a simple busy-for-N-cycles transmitter model.
module tb_serial_gpio_bridge;

  localparam int NP = 4;
  localparam int GW = 16;
  localparam int BUSY_LEN = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [NP*GW-1:0] gp_out;
  logic [NP*GW-1:0] gp_in;
  logic [NP-1:0] wr_strobe;

  int errors = 0;
  int checks = 0;

  int         busy_cnt = 0;
  int         tx_cnt = 0;
  int         strobe_cnt = 0;
  int         busy_viol = 0;
  logic [7:0] tx_log[$];

  int base_tx;
  int base_st;

  serial_gpio_bridge #(
    .NUM_PORTS(NP), .GP_WIDTH(GW), .TIMEOUT_CYCLES(50),
    .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .gp_out(gp_out), .gp_in(gp_in), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_cnt = tx_cnt + 1;
      tx_log.push_back(tx_data);
      if (tx_busy) busy_viol = busy_viol + 1;
    end
    if (wr_strobe !== '0) strobe_cnt = strobe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 8'hxx;
  endfunction

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; gp_in = '0;

    // reset with rx activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_valid = ~rx_valid;
      rx_data  = 8'h82;
    end
    rx_valid = 1'b0;
    chk("reset_gp_out", 64'(gp_out), 64'h0);
    chk("reset_strobe", 64'(wr_strobe), 64'h0);
    chk("reset_tx_data", 64'(tx_data), 64'h0);
    chk("reset_no_tx", 64'(tx_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // write port 2 = 0x1234, cycle-exact latency
    send_byte(8'h82); send_byte(8'h12); send_byte(8'h34);
    chk("wr_not_yet", 64'(gp_out), 64'h0);
    @(negedge clk);
    chk("wr_gp_out", 64'(gp_out), 64'h0000_1234_0000_0000);
    chk("wr_strobe", 64'(wr_strobe), 64'h4);
    @(negedge clk);
    chk("wr_strobe_off", 64'(wr_strobe), 64'h0);
    chk("ack_start", 64'(tx_start), 64'h1);
    chk("ack_data", 64'(tx_data), 64'hA5);
    // byte during the ACK transmit must be dropped
    send_byte(8'h02);
    idle(20);
    chk("ack_only_one_tx", 64'(tx_cnt), 64'd1);
    chk("strobe_once", 64'(strobe_cnt), 64'd1);

    // read port 1 with snapshot
    gp_in[GW*1 +: GW] = 16'hBEEF;
    base_tx = tx_cnt;
    send_byte(8'h01);
    @(negedge clk);
    chk("rd_latency_start", 64'(tx_start), 64'h1);
    gp_in[GW*1 +: GW] = 16'h0000;
    idle(30);
    chk("rd_count", 64'(tx_cnt - base_tx), 64'd2);
    chk("rd_byte0", 64'(log_at(base_tx)), 64'hBE);
    chk("rd_byte1", 64'(log_at(base_tx + 1)), 64'hEF);
    chk("rd_gp_out_same", 64'(gp_out), 64'h0000_1234_0000_0000);

    // bad index, write and read
    base_tx = tx_cnt;
    base_st = strobe_cnt;
    send_byte(8'h85);
    idle(20);
    chk("bad_w_count", 64'(tx_cnt - base_tx), 64'd1);
    chk("bad_w_byte", 64'(log_at(base_tx)), 64'hEE);
    send_byte(8'h07);
    idle(20);
    chk("bad_r_count", 64'(tx_cnt - base_tx), 64'd2);
    chk("bad_r_byte", 64'(log_at(base_tx + 1)), 64'hEE);
    chk("bad_gp_out", 64'(gp_out), 64'h0000_1234_0000_0000);
    chk("bad_no_strobe", 64'(strobe_cnt - base_st), 64'd0);

    // inter-byte timeout
    base_tx = tx_cnt;
    send_byte(8'h80); send_byte(8'h11);
    idle(60);
    chk("tmo_count", 64'(tx_cnt - base_tx), 64'd1);
    chk("tmo_byte", 64'(log_at(base_tx)), 64'hEE);
    chk("tmo_port0", 64'(gp_out), 64'h0000_1234_0000_0000);
    chk("tmo_no_strobe", 64'(strobe_cnt - base_st), 64'd0);
    send_byte(8'h80); send_byte(8'hAA); send_byte(8'hBB);
    idle(20);
    chk("post_tmo_write", 64'(gp_out), 64'h0000_1234_0000_AABB);
    chk("post_tmo_ack", 64'(log_at(base_tx + 1)), 64'hA5);
    chk("post_tmo_strobe", 64'(strobe_cnt - base_st), 64'd1);

    // same-value write still strobes
    send_byte(8'h80); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    chk("same_val_strobe", 64'(wr_strobe), 64'h1);
    idle(20);
    chk("same_val_gp_out", 64'(gp_out), 64'h0000_1234_0000_AABB);

    // reset mid-frame aborts
    base_tx = tx_cnt;
    base_st = strobe_cnt;
    send_byte(8'h83); send_byte(8'h55);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(20);
    chk("abort_gp_out", 64'(gp_out), 64'h0);
    chk("abort_no_strobe", 64'(strobe_cnt - base_st), 64'd0);
    chk("abort_no_tx", 64'(tx_cnt - base_tx), 64'd0);
    gp_in[GW*3 +: GW] = 16'h1357;
    send_byte(8'h03);
    idle(30);
    chk("abort_idle_rd_n", 64'(tx_cnt - base_tx), 64'd2);
    chk("abort_idle_rd0", 64'(log_at(base_tx)), 64'h13);
    chk("abort_idle_rd1", 64'(log_at(base_tx + 1)), 64'h57);

    chk("no_start_while_busy", 64'(busy_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
